// File: rtl/controller_cmd_pkg.sv
// Shared definitions for the USB command decoder: FSM states, command
// address map and parameter register reset values.
package controller_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    PAY_IDLE = 2'd2,
    PAY_WAIT = 2'd3
  } cmdState_t;

  // Single-word command addresses (header bit15 = 0)
  localparam logic [6:0] SW_MODE_SELECT     = 7'h00;
  localparam logic [6:0] SW_CHANNEL_MASK    = 7'h01;
  localparam logic [6:0] SW_DISCRI_MASK     = 7'h02;
  localparam logic [6:0] SW_CTEST_CHANNEL   = 7'h03;
  localparam logic [6:0] SW_SINGLE_TEST_CHN = 7'h04;
  localparam logic [6:0] SW_LEVEL_CTRL      = 7'h05;
  localparam logic [6:0] SW_ACQ_START_STOP  = 7'h06;
  localparam logic [6:0] SW_PULSE           = 7'h07;

  // Two-word command addresses (header bit15 = 1)
  localparam logic [6:0] TW_DAC0        = 7'h00;
  localparam logic [6:0] TW_DAC1        = 7'h01;
  localparam logic [6:0] TW_DAC2        = 7'h02;
  localparam logic [6:0] TW_START_DAC   = 7'h03;
  localparam logic [6:0] TW_END_DAC     = 7'h04;
  localparam logic [6:0] TW_MAX_PACKAGE = 7'h05;
  localparam logic [6:0] TW_CPT_MAX     = 7'h06;
  localparam logic [6:0] TW_COUNTER_MAX = 7'h07;

  localparam logic [1:0]  RST_MODE_SELECT     = 2'b00;
  localparam logic [9:0]  RST_DAC             = 10'd0;
  localparam logic [6:0]  RST_CHANNEL_MASK    = 7'h7F;
  localparam logic [1:0]  RST_DISCRI_MASK     = 2'b00;
  localparam logic [6:0]  RST_CTEST_CHANNEL   = 7'h00;
  localparam logic [5:0]  RST_SINGLE_TEST_CHN = 6'd0;
  localparam logic        RST_SC_OR_READREG   = 1'b1;
  localparam logic        RST_LEVEL           = 1'b0;
  localparam logic [15:0] RST_WORD16          = 16'h0000;
  localparam logic [15:0] RST_CPT_MAX         = 16'hFFFF;

  function automatic logic cmdAddrKnown(input logic twoWord, input logic [6:0] addr);
    if (twoWord) return (addr <= TW_COUNTER_MAX);
    return (addr <= SW_PULSE);
  endfunction

endpackage

// File: rtl/cmd_param_regfile.sv
// Parameter register file: decodes write strobes from the command FSM into
// level registers, one-cycle pulses, the error pulse and the command counter.
module cmd_param_regfile
  import controller_cmd_pkg::*;
(
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        wrEn,
  input  logic        wrTwoWord,
  input  logic [6:0]  wrAddr,
  input  logic [15:0] wrData,
  output logic [1:0]  ModeSelect,
  output logic [9:0]  Microroc10bitDAC0,
  output logic [9:0]  Microroc10bitDAC1,
  output logic [9:0]  Microroc10bitDAC2,
  output logic [6:0]  MicrorocChannelMask,
  output logic [1:0]  MicrorocDiscriMask,
  output logic [6:0]  MicrorocCTestChannel,
  output logic        SC_or_Readreg,
  output logic        TrigEffi_or_CountEffi,
  output logic        Single_or_64Chn,
  output logic        CTest_or_Input,
  output logic        AcqStartStop,
  output logic [5:0]  SingleTestChannel,
  output logic [9:0]  StartDAC,
  output logic [9:0]  EndDAC,
  output logic [15:0] MaxPackageNumber,
  output logic [15:0] CPT_MAX,
  output logic [15:0] CounterMAX,
  output logic        SCParameterLoad,
  output logic        SweepStart,
  output logic        CmdError,
  output logic [15:0] CmdCount
);

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      ModeSelect            <= RST_MODE_SELECT;
      Microroc10bitDAC0     <= RST_DAC;
      Microroc10bitDAC1     <= RST_DAC;
      Microroc10bitDAC2     <= RST_DAC;
      MicrorocChannelMask   <= RST_CHANNEL_MASK;
      MicrorocDiscriMask    <= RST_DISCRI_MASK;
      MicrorocCTestChannel  <= RST_CTEST_CHANNEL;
      SC_or_Readreg         <= RST_SC_OR_READREG;
      TrigEffi_or_CountEffi <= RST_LEVEL;
      Single_or_64Chn       <= RST_LEVEL;
      CTest_or_Input        <= RST_LEVEL;
      AcqStartStop          <= RST_LEVEL;
      SingleTestChannel     <= RST_SINGLE_TEST_CHN;
      StartDAC              <= RST_DAC;
      EndDAC                <= RST_DAC;
      MaxPackageNumber      <= RST_WORD16;
      CPT_MAX               <= RST_CPT_MAX;
      CounterMAX            <= RST_WORD16;
      SCParameterLoad       <= RST_LEVEL;
      SweepStart            <= RST_LEVEL;
      CmdError              <= RST_LEVEL;
      CmdCount              <= RST_WORD16;
    end else begin
      // Pulses fall back to zero unless re-armed by this cycle's write
      SCParameterLoad <= 1'b0;
      SweepStart      <= 1'b0;
      CmdError        <= 1'b0;
      if (wrEn) begin
        if (!wrTwoWord) begin
          case (wrAddr)
            SW_MODE_SELECT:     ModeSelect           <= wrData[1:0];
            SW_CHANNEL_MASK:    MicrorocChannelMask  <= wrData[6:0];
            SW_DISCRI_MASK:     MicrorocDiscriMask   <= wrData[1:0];
            SW_CTEST_CHANNEL:   MicrorocCTestChannel <= wrData[6:0];
            SW_SINGLE_TEST_CHN: SingleTestChannel    <= wrData[5:0];
            SW_LEVEL_CTRL: begin
              SC_or_Readreg         <= wrData[0];
              TrigEffi_or_CountEffi <= wrData[1];
              Single_or_64Chn       <= wrData[2];
              CTest_or_Input        <= wrData[3];
            end
            SW_ACQ_START_STOP:  AcqStartStop <= wrData[0];
            SW_PULSE: begin
              SCParameterLoad <= wrData[0];
              SweepStart      <= wrData[1];
            end
            default: ;
          endcase
        end else begin
          case (wrAddr)
            TW_DAC0:        Microroc10bitDAC0 <= wrData[9:0];
            TW_DAC1:        Microroc10bitDAC1 <= wrData[9:0];
            TW_DAC2:        Microroc10bitDAC2 <= wrData[9:0];
            TW_START_DAC:   StartDAC          <= wrData[9:0];
            TW_END_DAC:     EndDAC            <= wrData[9:0];
            TW_MAX_PACKAGE: MaxPackageNumber  <= wrData;
            TW_CPT_MAX:     CPT_MAX           <= wrData;
            TW_COUNTER_MAX: CounterMAX        <= wrData;
            default: ;
          endcase
        end
        if (cmdAddrKnown(wrTwoWord, wrAddr)) CmdCount <= CmdCount + 16'd1;
        else                                 CmdError <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_command_decoder.sv
// Host command decoder: pulls one- or two-word commands from the command FIFO
// and forwards decoded writes to the parameter register file.
//   state    | meaning
//   IDLE     | waiting for a header word; pops it when the FIFO has data
//   HDR_WAIT | header on CmdFifoData; execute single-word or latch address
//   PAY_IDLE | header latched; waiting for the payload word
//   PAY_WAIT | payload on CmdFifoData; execute two-word command
module usb_command_decoder
  import controller_cmd_pkg::*;
(
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        CmdFifoEmpty,
  output logic        CmdFifoRdEn,
  input  logic [15:0] CmdFifoData,
  output logic [1:0]  ModeSelect,
  output logic [9:0]  Microroc10bitDAC0,
  output logic [9:0]  Microroc10bitDAC1,
  output logic [9:0]  Microroc10bitDAC2,
  output logic [6:0]  MicrorocChannelMask,
  output logic [1:0]  MicrorocDiscriMask,
  output logic [6:0]  MicrorocCTestChannel,
  output logic        SC_or_Readreg,
  output logic        TrigEffi_or_CountEffi,
  output logic        Single_or_64Chn,
  output logic        CTest_or_Input,
  output logic        AcqStartStop,
  output logic [5:0]  SingleTestChannel,
  output logic [9:0]  StartDAC,
  output logic [9:0]  EndDAC,
  output logic [15:0] MaxPackageNumber,
  output logic [15:0] CPT_MAX,
  output logic [15:0] CounterMAX,
  output logic        SCParameterLoad,
  output logic        SweepStart,
  output logic        CmdError,
  output logic [15:0] CmdCount
);

  cmdState_t   state, nextState;
  logic [6:0]  hdrAddr;
  logic        rdEn;
  logic        wrEn;
  logic        wrTwoWord;
  logic [6:0]  wrAddr;
  logic [15:0] wrData;

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      hdrAddr <= 7'd0;
    end else begin
      state <= nextState;
      if (state == HDR_WAIT && CmdFifoData[15]) hdrAddr <= CmdFifoData[14:8];
    end
  end

  always_comb begin
    nextState = state;
    rdEn      = 1'b0;
    wrEn      = 1'b0;
    wrTwoWord = 1'b0;
    wrAddr    = CmdFifoData[14:8];
    wrData    = {8'h00, CmdFifoData[7:0]};
    case (state)
      IDLE: begin
        if (!CmdFifoEmpty) begin
          rdEn      = 1'b1;
          nextState = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (CmdFifoData[15]) begin
          nextState = PAY_IDLE;
        end else begin
          wrEn      = 1'b1;
          nextState = IDLE;
        end
      end
      PAY_IDLE: begin
        if (!CmdFifoEmpty) begin
          rdEn      = 1'b1;
          nextState = PAY_WAIT;
        end
      end
      PAY_WAIT: begin
        wrEn      = 1'b1;
        wrTwoWord = 1'b1;
        wrAddr    = hdrAddr;
        wrData    = CmdFifoData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Reset is synchronous, so gate the strobe directly to keep the FIFO quiet
  assign CmdFifoRdEn = rdEn & reset_n;

  cmd_param_regfile uRegfile (
    .Clk                   (Clk),
    .reset_n               (reset_n),
    .wrEn                  (wrEn),
    .wrTwoWord             (wrTwoWord),
    .wrAddr                (wrAddr),
    .wrData                (wrData),
    .ModeSelect            (ModeSelect),
    .Microroc10bitDAC0     (Microroc10bitDAC0),
    .Microroc10bitDAC1     (Microroc10bitDAC1),
    .Microroc10bitDAC2     (Microroc10bitDAC2),
    .MicrorocChannelMask   (MicrorocChannelMask),
    .MicrorocDiscriMask    (MicrorocDiscriMask),
    .MicrorocCTestChannel  (MicrorocCTestChannel),
    .SC_or_Readreg         (SC_or_Readreg),
    .TrigEffi_or_CountEffi (TrigEffi_or_CountEffi),
    .Single_or_64Chn       (Single_or_64Chn),
    .CTest_or_Input        (CTest_or_Input),
    .AcqStartStop          (AcqStartStop),
    .SingleTestChannel     (SingleTestChannel),
    .StartDAC              (StartDAC),
    .EndDAC                (EndDAC),
    .MaxPackageNumber      (MaxPackageNumber),
    .CPT_MAX               (CPT_MAX),
    .CounterMAX            (CounterMAX),
    .SCParameterLoad       (SCParameterLoad),
    .SweepStart            (SweepStart),
    .CmdError              (CmdError),
    .CmdCount              (CmdCount)
  );

endmodule

// File: tb/tb_usb_command_decoder.sv
// Self-checking bench for usb_command_decoder: queue-based FIFO model,
// command-level reference model, vector table, directed and random streams.
module tb_usb_command_decoder;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        CmdFifoEmpty = 1'b1;
  logic        CmdFifoRdEn;
  logic [15:0] CmdFifoData = 16'h0000;
  logic [1:0]  ModeSelect;
  logic [9:0]  Microroc10bitDAC0, Microroc10bitDAC1, Microroc10bitDAC2;
  logic [6:0]  MicrorocChannelMask;
  logic [1:0]  MicrorocDiscriMask;
  logic [6:0]  MicrorocCTestChannel;
  logic        SC_or_Readreg, TrigEffi_or_CountEffi, Single_or_64Chn, CTest_or_Input, AcqStartStop;
  logic [5:0]  SingleTestChannel;
  logic [9:0]  StartDAC, EndDAC;
  logic [15:0] MaxPackageNumber, CPT_MAX, CounterMAX;
  logic        SCParameterLoad, SweepStart, CmdError;
  logic [15:0] CmdCount;

  usb_command_decoder dut (
    .Clk(Clk), .reset_n(reset_n), .CmdFifoEmpty(CmdFifoEmpty), .CmdFifoRdEn(CmdFifoRdEn),
    .CmdFifoData(CmdFifoData), .ModeSelect(ModeSelect),
    .Microroc10bitDAC0(Microroc10bitDAC0), .Microroc10bitDAC1(Microroc10bitDAC1),
    .Microroc10bitDAC2(Microroc10bitDAC2), .MicrorocChannelMask(MicrorocChannelMask),
    .MicrorocDiscriMask(MicrorocDiscriMask), .MicrorocCTestChannel(MicrorocCTestChannel),
    .SC_or_Readreg(SC_or_Readreg), .TrigEffi_or_CountEffi(TrigEffi_or_CountEffi),
    .Single_or_64Chn(Single_or_64Chn), .CTest_or_Input(CTest_or_Input),
    .AcqStartStop(AcqStartStop), .SingleTestChannel(SingleTestChannel),
    .StartDAC(StartDAC), .EndDAC(EndDAC), .MaxPackageNumber(MaxPackageNumber),
    .CPT_MAX(CPT_MAX), .CounterMAX(CounterMAX), .SCParameterLoad(SCParameterLoad),
    .SweepStart(SweepStart), .CmdError(CmdError), .CmdCount(CmdCount)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO model: a read strobe seen during a cycle pops the queue just after
  // the rising edge, so the word is on CmdFifoData during the following cycle.
  logic [15:0] fifoQ[$];
  logic rdSeen = 1'b0;
  int   rdOnEmpty = 0;
  int   cyc = 0;

  always @(posedge Clk) begin
    cyc++;
    if (rdSeen) begin
      #1;
      if (fifoQ.size() == 0) rdOnEmpty++;
      else CmdFifoData = fifoQ.pop_front();
      CmdFifoEmpty = (fifoQ.size() == 0);
    end
  end

  int rdCycles[$], scCycles[$], errCycles[$], modeCycles[$], startCycles[$];
  int scTotal = 0, sweepTotal = 0, errTotal = 0;
  int pulseViol = 0, rdEmptyViol = 0, rdResetViol = 0;
  logic prevSc = 1'b0, prevSw = 1'b0, prevErr = 1'b0;
  logic [1:0] prevMode = 2'b00;
  logic [9:0] prevStart = 10'd0;

  always @(negedge Clk) begin
    rdSeen = CmdFifoRdEn;
    if (CmdFifoRdEn) rdCycles.push_back(cyc);
    if (CmdFifoRdEn && CmdFifoEmpty) rdEmptyViol++;
    if (CmdFifoRdEn && !reset_n) rdResetViol++;
    if (SCParameterLoad) begin scCycles.push_back(cyc); scTotal++; end
    if (SweepStart) sweepTotal++;
    if (CmdError) begin errCycles.push_back(cyc); errTotal++; end
    if ((SCParameterLoad && prevSc) || (SweepStart && prevSw) || (CmdError && prevErr)) pulseViol++;
    if (ModeSelect !== prevMode) modeCycles.push_back(cyc);
    if (StartDAC !== prevStart) startCycles.push_back(cyc);
    prevSc = SCParameterLoad; prevSw = SweepStart; prevErr = CmdError;
    prevMode = ModeSelect; prevStart = StartDAC;
  end

  // Reference model: the parameter set as the host sees it after each command.
  logic [1:0]  mMode, mDiscri;
  logic [9:0]  mDac0, mDac1, mDac2, mStart, mEnd;
  logic [6:0]  mMask, mCtest;
  logic [5:0]  mSingle;
  logic        mSc, mTrig, mS64, mCtIn, mAcq;
  logic [15:0] mMaxPkg, mCpt, mCntMax;
  int mCount = 0, mScP = 0, mSwP = 0, mErrP = 0;

  task automatic modelReset();
    mMode = 0; mDiscri = 0; mDac0 = 0; mDac1 = 0; mDac2 = 0; mStart = 0; mEnd = 0;
    mMask = 7'h7F; mCtest = 0; mSingle = 0; mSc = 1; mTrig = 0; mS64 = 0; mCtIn = 0;
    mAcq = 0; mMaxPkg = 0; mCpt = 16'hFFFF; mCntMax = 0; mCount = 0;
  endtask

  task automatic modelCmd(input logic [15:0] h, input logic [15:0] p);
    int a;
    a = int'(h[14:8]);
    if (a > 7) begin mErrP++; return; end
    mCount++;
    if (!h[15]) begin
      case (a)
        0: mMode = h[1:0];
        1: mMask = h[6:0];
        2: mDiscri = h[1:0];
        3: mCtest = h[6:0];
        4: mSingle = h[5:0];
        5: begin mSc = h[0]; mTrig = h[1]; mS64 = h[2]; mCtIn = h[3]; end
        6: mAcq = h[0];
        default: begin if (h[0]) mScP++; if (h[1]) mSwP++; end
      endcase
    end else begin
      case (a)
        0: mDac0 = p[9:0];
        1: mDac1 = p[9:0];
        2: mDac2 = p[9:0];
        3: mStart = p[9:0];
        4: mEnd = p[9:0];
        5: mMaxPkg = p;
        6: mCpt = p;
        default: mCntMax = p;
      endcase
    end
  endtask

  task automatic compareAll(input string tag);
    check({tag, "_ModeSelect"}, ModeSelect, mMode);
    check({tag, "_DAC0"}, Microroc10bitDAC0, mDac0);
    check({tag, "_DAC1"}, Microroc10bitDAC1, mDac1);
    check({tag, "_DAC2"}, Microroc10bitDAC2, mDac2);
    check({tag, "_ChannelMask"}, MicrorocChannelMask, mMask);
    check({tag, "_DiscriMask"}, MicrorocDiscriMask, mDiscri);
    check({tag, "_CTestChannel"}, MicrorocCTestChannel, mCtest);
    check({tag, "_LevelBits"}, {SC_or_Readreg, TrigEffi_or_CountEffi, Single_or_64Chn, CTest_or_Input, AcqStartStop},
          {mSc, mTrig, mS64, mCtIn, mAcq});
    check({tag, "_SingleTestChannel"}, SingleTestChannel, mSingle);
    check({tag, "_StartDAC"}, StartDAC, mStart);
    check({tag, "_EndDAC"}, EndDAC, mEnd);
    check({tag, "_MaxPackageNumber"}, MaxPackageNumber, mMaxPkg);
    check({tag, "_CPT_MAX"}, CPT_MAX, mCpt);
    check({tag, "_CounterMAX"}, CounterMAX, mCntMax);
    check({tag, "_CmdCount"}, CmdCount, mCount & 32'hFFFF);
    check({tag, "_SCLoadPulses"}, scTotal, mScP);
    check({tag, "_SweepPulses"}, sweepTotal, mSwP);
    check({tag, "_ErrorPulses"}, errTotal, mErrP);
  endtask

  task automatic pushWord(input logic [15:0] w);
    @(posedge Clk); #2;
    fifoQ.push_back(w);
    CmdFifoEmpty = 1'b0;
  endtask

  task automatic pushPair(input logic [15:0] w0, input logic [15:0] w1);
    @(posedge Clk); #2;
    fifoQ.push_back(w0);
    fifoQ.push_back(w1);
    CmdFifoEmpty = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (fifoQ.size() != 0 && n < budget) begin @(negedge Clk); n++; end
    check({tag, "_drain_timeout"}, fifoQ.size(), 0);
    repeat (4) @(negedge Clk);
  endtask

  task automatic doReset();
    @(posedge Clk); #2;
    reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    reset_n = 1'b1;
    modelReset();
  endtask

  task automatic clearLogs();
    rdCycles.delete(); scCycles.delete(); errCycles.delete();
    modeCycles.delete(); startCycles.delete();
  endtask

  function automatic int firstOr(input int q[$], input int idx);
    if (q.size() > idx) return q[idx];
    return -1;
  endfunction

  function automatic logic [15:0] getOut(input int sel);
    case (sel)
      0:  return {14'd0, ModeSelect};
      1:  return {9'd0, MicrorocChannelMask};
      2:  return {14'd0, MicrorocDiscriMask};
      3:  return {9'd0, MicrorocCTestChannel};
      4:  return {10'd0, SingleTestChannel};
      5:  return {15'd0, SC_or_Readreg};
      6:  return {15'd0, TrigEffi_or_CountEffi};
      9:  return {15'd0, AcqStartStop};
      10: return {6'd0, Microroc10bitDAC0};
      11: return {6'd0, Microroc10bitDAC1};
      12: return {6'd0, Microroc10bitDAC2};
      14: return {6'd0, EndDAC};
      15: return MaxPackageNumber;
      16: return CPT_MAX;
      default: return CounterMAX;
    endcase
  endfunction

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          sel;
    logic [15:0] expVal;
    int          expCntDelta;
    int          expErr;
    int          expSc;
    int          expSweep;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int baseCnt, baseErr, baseSc, baseSw;
    logic [15:0] h, p;

    vecs.push_back('{16'h0001, 16'h0000, 0,  16'h0001, 1, 0, 0, 0});
    vecs.push_back('{16'h0155, 16'h0000, 1,  16'h0055, 1, 0, 0, 0});
    vecs.push_back('{16'h02FE, 16'h0000, 2,  16'h0002, 1, 0, 0, 0});
    vecs.push_back('{16'h03FF, 16'h0000, 3,  16'h007F, 1, 0, 0, 0});
    vecs.push_back('{16'h04AA, 16'h0000, 4,  16'h002A, 1, 0, 0, 0});
    vecs.push_back('{16'h050E, 16'h0000, 5,  16'h0000, 1, 0, 0, 0});
    vecs.push_back('{16'h050E, 16'h0000, 6,  16'h0001, 1, 0, 0, 0});
    vecs.push_back('{16'h0601, 16'h0000, 9,  16'h0001, 1, 0, 0, 0});
    vecs.push_back('{16'h0703, 16'h0000, 9,  16'h0001, 1, 0, 1, 1});
    vecs.push_back('{16'h0702, 16'h0000, 9,  16'h0001, 1, 0, 0, 1});
    vecs.push_back('{16'h8055, 16'hFFFF, 10, 16'h03FF, 1, 0, 0, 0});
    vecs.push_back('{16'h8100, 16'h0123, 11, 16'h0123, 1, 0, 0, 0});
    vecs.push_back('{16'h8200, 16'hFE00, 12, 16'h0200, 1, 0, 0, 0});
    vecs.push_back('{16'h8400, 16'hABCD, 14, 16'h03CD, 1, 0, 0, 0});
    vecs.push_back('{16'h8500, 16'hBEEF, 15, 16'hBEEF, 1, 0, 0, 0});
    vecs.push_back('{16'h8600, 16'h0042, 16, 16'h0042, 1, 0, 0, 0});
    vecs.push_back('{16'h8700, 16'h8001, 17, 16'h8001, 1, 0, 0, 0});
    vecs.push_back('{16'h0A00, 16'h0000, 0,  16'h0001, 0, 1, 0, 0});
    vecs.push_back('{16'h7F12, 16'h0000, 1,  16'h0055, 0, 1, 0, 0});
    vecs.push_back('{16'h8800, 16'h5555, 17, 16'h8001, 0, 1, 0, 0});

    // Reset values, and no read strobe while the FIFO stays empty
    modelReset();
    repeat (3) @(posedge Clk);
    #2 reset_n = 1'b1;
    clearLogs();
    repeat (10) @(negedge Clk);
    compareAll("reset");
    check("reset_no_rd_when_empty", rdCycles.size(), 0);

    // Back-to-back single-word commands
    clearLogs();
    pushPair(16'h0002, 16'h0701);
    modelCmd(16'h0002, 16'h0000);
    modelCmd(16'h0701, 16'h0000);
    drain("b2b", 50);
    check("b2b_rd_count", rdCycles.size(), 2);
    check("b2b_rd_spacing", firstOr(rdCycles, 1) - firstOr(rdCycles, 0), 2);
    check("b2b_mode_latency", firstOr(modeCycles, 0), firstOr(rdCycles, 0) + 2);
    check("b2b_scload_latency", firstOr(scCycles, 0), firstOr(rdCycles, 1) + 2);
    check("b2b_scload_count", scCycles.size(), 1);
    check("b2b_ModeSelect", ModeSelect, 2);
    check("b2b_CmdCount", CmdCount, 2);
    compareAll("b2b");

    // Header, long empty gap, then payload
    clearLogs();
    pushWord(16'h8300);
    repeat (20) @(negedge Clk);
    check("gap_single_rd_while_empty", rdCycles.size(), 1);
    pushWord(16'h0155);
    modelCmd(16'h8300, 16'h0155);
    drain("gap", 50);
    check("gap_rd_count", rdCycles.size(), 2);
    check("gap_startdac_latency", firstOr(startCycles, 0), firstOr(rdCycles, 1) + 2);
    check("gap_StartDAC", StartDAC, 10'h155);
    compareAll("gap");

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      baseCnt = int'(CmdCount); baseErr = errTotal; baseSc = scTotal; baseSw = sweepTotal;
      if (vecs[i].w0[15]) pushPair(vecs[i].w0, vecs[i].w1);
      else pushWord(vecs[i].w0);
      modelCmd(vecs[i].w0, vecs[i].w1);
      drain($sformatf("vec%0d", i), 50);
      check($sformatf("vec%0d_value", i), getOut(vecs[i].sel), vecs[i].expVal);
      check($sformatf("vec%0d_count_delta", i), (int'(CmdCount) - baseCnt) & 32'hFFFF, vecs[i].expCntDelta);
      check($sformatf("vec%0d_err_delta", i), errTotal - baseErr, vecs[i].expErr);
      check($sformatf("vec%0d_sc_delta", i), scTotal - baseSc, vecs[i].expSc);
      check($sformatf("vec%0d_sweep_delta", i), sweepTotal - baseSw, vecs[i].expSweep);
      compareAll($sformatf("vec%0d", i));
    end

    // Unknown addresses: single-word and two-word
    clearLogs();
    baseCnt = int'(CmdCount);
    @(posedge Clk); #2;
    fifoQ.push_back(16'h7F00); fifoQ.push_back(16'h9000); fifoQ.push_back(16'h1234);
    CmdFifoEmpty = 1'b0;
    modelCmd(16'h7F00, 16'h0000);
    modelCmd(16'h9000, 16'h1234);
    drain("unk", 50);
    check("unk_err_pulses", errCycles.size(), 2);
    check("unk_words_consumed", rdCycles.size(), 3);
    check("unk_err2_latency", firstOr(errCycles, 1), firstOr(rdCycles, 2) + 2);
    check("unk_count_unchanged", CmdCount, baseCnt);
    compareAll("unk");

    // Random command stream with gaps between and inside commands
    for (int i = 0; i < 60; i++) begin
      h = 16'($urandom);
      h[14:8] = 7'($urandom_range(0, 9));
      p = 16'($urandom);
      pushWord(h);
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      if (h[15]) begin
        pushWord(p);
        repeat ($urandom_range(0, 2)) @(posedge Clk);
      end
      modelCmd(h, p);
    end
    drain("rand", 200);
    compareAll("rand");

    // Reset while waiting for a payload discards the header
    pushWord(16'h8600);
    drain("midrst_hdr", 50);
    doReset();
    pushWord(16'h0003);
    modelCmd(16'h0003, 16'h0000);
    drain("midrst", 50);
    check("midrst_ModeSelect", ModeSelect, 3);
    check("midrst_CPT_MAX", CPT_MAX, 16'hFFFF);
    check("midrst_CmdCount", CmdCount, 1);
    compareAll("midrst");

    // Command counter wrap
    doReset();
    clearLogs();
    @(posedge Clk); #2;
    for (int i = 0; i < 65537; i++) begin
      fifoQ.push_back(16'h0601);
      modelCmd(16'h0601, 16'h0000);
    end
    CmdFifoEmpty = 1'b0;
    drain("wrap", 140000);
    check("wrap_CmdCount", CmdCount, 16'h0001);
    compareAll("wrap");

    check("pulse_width_violations", pulseViol, 0);
    check("rd_while_empty", rdEmptyViol, 0);
    check("rd_during_reset", rdResetViol, 0);
    check("pop_from_empty_fifo", rdOnEmpty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/usb_command_decoder.md
USB_COMMAND_DECODER -- requirements
Module: usb_command_decoder

Interface
REQ-001 Clk  in  1  system clock; all logic on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 CmdFifoEmpty  in  1  host-to-FPGA command FIFO empty flag.
REQ-004 CmdFifoRdEn  out  1  FIFO read strobe; data valid the cycle after.
REQ-005 CmdFifoData  in  16  command word.
REQ-006 ModeSelect  out  2  ACQ, SweepACQ or SCurve mode.
REQ-007 Microroc10bitDAC0 / Microroc10bitDAC1 / Microroc10bitDAC2  out  10 each  threshold DACs.
REQ-008 MicrorocChannelMask  out  7;  MicrorocDiscriMask  out  2;  MicrorocCTestChannel  out  7.
REQ-009 SC_or_Readreg, TrigEffi_or_CountEffi, Single_or_64Chn, CTest_or_Input, AcqStartStop  out  1 each  level controls.
REQ-010 SingleTestChannel  out  6;  StartDAC, EndDAC  out  10 each.
REQ-011 MaxPackageNumber, CPT_MAX, CounterMAX  out  16 each.
REQ-012 SCParameterLoad, SweepStart, CmdError  out  1 each  single-cycle pulses.
REQ-013 CmdCount  out  16  count of accepted commands, wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states: IDLE, HDR_WAIT, PAY_IDLE, PAY_WAIT.
REQ-015 IDLE: if !CmdFifoEmpty, CmdFifoRdEn=1 for one cycle, next state HDR_WAIT; CmdFifoRdEn is never high while CmdFifoEmpty=1.
REQ-016 HDR_WAIT: sample CmdFifoData as header. If bit15=0, execute the single-word command, then go to IDLE. If bit15=1, latch the address and go to PAY_IDLE.
REQ-017 PAY_IDLE: wait indefinitely for !CmdFifoEmpty, then CmdFifoRdEn=1 for one cycle, next state PAY_WAIT.
REQ-018 PAY_WAIT: sample the payload, execute the two-word command, then go to IDLE.
REQ-019 Latency: RdEn high in cycle N; word sampled in cycle N+1; register or pulse visible in cycle N+2. Maximum throughput is one word per two cycles.
REQ-020 Single-word commands: addr=[14:8], d=[7:0].
  - 0x00: ModeSelect<=d[1:0]
  - 0x01: ChannelMask<=d[6:0]
  - 0x02: DiscriMask<=d[1:0]
  - 0x03: CTestChannel<=d[6:0]
  - 0x04: SingleTestChannel<=d[5:0]
  - 0x05: d0 SC_or_Readreg, d1 TrigEffi_or_CountEffi, d2 Single_or_64Chn, d3 CTest_or_Input
  - 0x06: AcqStartStop<=d0
  - 0x07: d0 pulses SCParameterLoad, d1 pulses SweepStart; both may pulse in the same cycle
REQ-021 Two-word commands: addr=[14:8], payload p.
  - 0x00–0x02: DAC0–DAC2<=p[9:0]
  - 0x03: StartDAC<=p[9:0]
  - 0x04: EndDAC<=p[9:0]
  - 0x05: MaxPackageNumber<=p
  - 0x06: CPT_MAX<=p
  - 0x07: CounterMAX<=p
REQ-022 Unknown single-word address: no register change, CmdError pulses. Unknown two-word address: payload is still consumed and discarded, then CmdError pulses.
REQ-023 CmdCount increments by one on each valid executed command, in the same cycle the command takes effect; errors do not count.
REQ-024 Pulses are exactly one cycle wide, and are never asserted except on command execution.
REQ-025 Writing a register leaves all other registers unchanged; a repeated write with the same value is legal and still counts.

Reset
REQ-026 On reset_n=0 at a rising edge, the block enters IDLE and every output takes its reset value: all outputs 0, except SC_or_Readreg=1, MicrorocChannelMask=7'h7F and CPT_MAX=16'hFFFF.
REQ-027 Reset mid-command discards any latched header; the next FIFO word is treated as a header.
REQ-028 CmdFifoRdEn=0 during reset.

Structure
REQ-029 Shared package controller_cmd_pkg SHALL hold the FSM state enum, the single-word and two-word address constants, and the reset-value constants.
REQ-030 Single RTL module; one sub-module is natural: cmd_param_regfile, holding the parameter registers and pulse generation, driven by addr/data/write-strobe from the FSM.

Verification
REQ-031 Reset: all outputs match REQ-026; CmdFifoRdEn stays 0 while the FIFO is empty.
REQ-032 Write words 0x0002 then 0x0701 back-to-back -> ModeSelect=2, then SCParameterLoad pulses for one cycle two cycles after its RdEn; CmdCount=2.
REQ-033 Write 0x8300, hold the FIFO empty 20 cycles, then write 0x0155 -> StartDAC=0x155 in cycle N+2 after the payload RdEn; no RdEn pulse while the FIFO is empty.
REQ-034 Write 0x7F00, then 0x9000 followed by 0x1234 -> two CmdError pulses, no register changes, CmdCount unchanged, both words of the second command consumed.
REQ-035 Write 0x8600, assert reset in PAY_IDLE, release, then write 0x0003 -> ModeSelect=3, CPT_MAX=0xFFFF, CmdCount=1.
REQ-036 Issue 65537 valid commands -> CmdCount wraps to 0x0001.
